// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//   Round-robin arbiter that owns the select of a 4-bit, 4:1 mux. Four
//   requesters raise req[i] and present data on a/b/c/d. The grant is
//   registered, so exactly one source reaches y at a time.
//
//   Optional feature macro: GRANT_TIMEOUT_EN
//     defined   - an owner that has held the grant for MAX_HOLD cycles is
//                 preempted when another request is pending.
//     undefined - the owner keeps the grant until it drops its own req.
//
// Ports
//   clk    in  1  system clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   req    in  4  request per source (bit i pairs with a/b/c/d)
//   a..d   in  4  data of sources 0..3
//   grant  out 4  one-hot registered grant, 0 when idle
//   sel    out 2  registered mux select, holds last owner when idle
//   y      out 4  owner data when valid, else 0
//   valid  out 1  high while grant != 0
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic [3:0] d,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic [3:0] y,
    output logic       valid
);

    // Elaboration-time guard on the hold-counter configuration.
    if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_param
        $error("rr_mux_arbiter: MAX_HOLD must be in 2..2**CNT_W");
    end

    typedef enum logic {IDLE, OWN} state_t;

    state_t     state, state_nx;
    logic [3:0] grant_nx;
    logic [1:0] sel_nx;
    logic [1:0] last_owner, last_nx;
    logic [2:0] win;        // {found, index}
    logic       owner_req;
    logic       take;

    // Round-robin search starting one past the last owner; the last owner
    // itself is examined last, so it only wins when nobody else asks.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = last + k[1:0];
            if (!res[2] && r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign win       = rr_pick(req, last_owner);
    assign owner_req = |(req & grant);

`ifdef GRANT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             others;

    assign others = |(req & ~grant);
`endif

    // NOTE: every variable is given a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        sel_nx   = sel;
        last_nx  = last_owner;
        take     = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        cnt_nx   = cnt;
`endif
        case (state)
            IDLE: begin
                if (win[2]) take = 1'b1;
            end
            OWN: begin
                if (!owner_req) begin
                    if (win[2]) begin
                        take = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        grant_nx = 4'b0000;
                    end
`ifdef GRANT_TIMEOUT_EN
                end else if (cnt == HOLD_LAST) begin
                    // Timeout: rotate if someone else waits, otherwise
                    // restart the hold window for the current owner.
                    if (others) take = 1'b1;
                    else        cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase

        if (take) begin
            state_nx = OWN;
            grant_nx = 4'b0001 << win[1:0];
            sel_nx   = win[1:0];
            last_nx  = win[1:0];
`ifdef GRANT_TIMEOUT_EN
            cnt_nx   = '0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 4'b0000;
            sel        <= 2'b00;
            last_owner <= 2'd3;     // source 0 is first in line after reset
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            sel        <= sel_nx;
            last_owner <= last_nx;
        end
    end

`ifdef GRANT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_nx;
    end
`endif

    assign valid = |grant;

    // Combinational mux so owner data changes reach y in the same cycle.
    always_comb begin
        y = 4'b0000;
        if (valid) begin
            case (sel)
                2'd0:    y = a;
                2'd1:    y = b;
                2'd2:    y = c;
                default: y = d;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
//   Self-checking bench for rr_mux_arbiter: a table of per-cycle vectors
//   whose expected outputs go through a scoreboard queue, followed by
//   hand-written sequences for idle, mid-cycle data change, hold/timeout
//   and asynchronous reset during a grant.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req, a, b, c, d;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [3:0] y;
    logic       valid;

    rr_mux_arbiter #(.MAX_HOLD(8), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .grant (grant),
        .sel   (sel),
        .y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] a, b, c, d;
        logic [3:0] g;
        logic [1:0] s;
        logic [3:0] y;
        logic       v;
    } vec_t;

    vec_t vecs[16];
    vec_t sb_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] da,
                                input logic [3:0] g, input logic [1:0] s,
                                input logic [3:0] yy, input logic v);
        vec_t t;
        t.req = r; t.a = da; t.b = 4'd2; t.c = 4'd4; t.d = 4'd8;
        t.g = g; t.s = s; t.y = yy; t.v = v;
        return t;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        a = 4'd1; b = 4'd2; c = 4'd4; d = 4'd8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        logic [3:0] exp_g;

        // req, a, grant, sel, y, valid -- applied one per cycle from reset.
        vecs[0]  = mk(4'b1111, 4'h1, 4'b0001, 2'd0, 4'h1, 1'b1);
        vecs[1]  = mk(4'b1110, 4'h1, 4'b0010, 2'd1, 4'h2, 1'b1);
        vecs[2]  = mk(4'b1100, 4'h1, 4'b0100, 2'd2, 4'h4, 1'b1);
        vecs[3]  = mk(4'b1000, 4'h1, 4'b1000, 2'd3, 4'h8, 1'b1);
        vecs[4]  = mk(4'b1000, 4'h1, 4'b1000, 2'd3, 4'h8, 1'b1);
        vecs[5]  = mk(4'b0000, 4'h1, 4'b0000, 2'd3, 4'h0, 1'b0);
        vecs[6]  = mk(4'b0000, 4'h1, 4'b0000, 2'd3, 4'h0, 1'b0);
        vecs[7]  = mk(4'b0001, 4'h1, 4'b0001, 2'd0, 4'h1, 1'b1);
        vecs[8]  = mk(4'b0001, 4'hC, 4'b0001, 2'd0, 4'hC, 1'b1);
        vecs[9]  = mk(4'b0100, 4'hC, 4'b0100, 2'd2, 4'h4, 1'b1);
        vecs[10] = mk(4'b1101, 4'hC, 4'b0100, 2'd2, 4'h4, 1'b1);
        vecs[11] = mk(4'b1001, 4'hC, 4'b1000, 2'd3, 4'h8, 1'b1);
        vecs[12] = mk(4'b1001, 4'hC, 4'b1000, 2'd3, 4'h8, 1'b1);
        vecs[13] = mk(4'b0001, 4'hC, 4'b0001, 2'd0, 4'hC, 1'b1);
        vecs[14] = mk(4'b0110, 4'hC, 4'b0010, 2'd1, 4'h2, 1'b1);
        vecs[15] = mk(4'b0000, 4'hC, 4'b0000, 2'd1, 4'h0, 1'b0);

        // Reset state, checked while requests are already asserted.
        rst_n = 1'b0;
        req = 4'b1111; a = 4'd1; b = 4'd2; c = 4'd4; d = 4'd8;
        repeat (2) @(posedge clk);
        #1;
        check("reset_grant", grant, 4'b0000);
        check("reset_sel",   {2'b00, sel}, 4'b0000);
        check("reset_valid", {3'b000, valid}, 4'b0000);
        check("reset_y",     y, 4'b0000);

        // Table-driven sequence through the scoreboard.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            req = vecs[i].req;
            a = vecs[i].a; b = vecs[i].b; c = vecs[i].c; d = vecs[i].d;
            sb_q.push_back(vecs[i]);
            after_edge();
            if (sb_q.size() == 0) begin
                check("sb_empty", 4'd0, 4'd1);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("vec%0d_grant", i), grant, e.g);
                check($sformatf("vec%0d_sel", i), {2'b00, sel}, {2'b00, e.s});
                check($sformatf("vec%0d_y", i), y, e.y);
                check($sformatf("vec%0d_valid", i), {3'b000, valid}, {3'b000, e.v});
            end
        end

        // No requests after reset: everything stays quiet.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            after_edge();
            check("idle_grant", grant, 4'b0000);
            check("idle_valid", {3'b000, valid}, 4'b0000);
            check("idle_y", y, 4'b0000);
            check("idle_sel", {2'b00, sel}, 4'b0000);
        end

        // Owner data changes mid-cycle and appears on y without an edge.
        do_reset();
        req = 4'b0001;
        after_edge();
        check("midchg_grant0", grant, 4'b0001);
        check("midchg_y0", y, 4'b0001);
        #2;
        a = 4'b1100;
        #1;
        check("midchg_y1", y, 4'b1100);
        check("midchg_grant1", grant, 4'b0001);

        // req=0011 held: with timeout the grant alternates every 8 cycles,
        // otherwise source 0 keeps it.
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 24; k++) begin
            after_edge();
`ifdef GRANT_TIMEOUT_EN
            exp_g = ((k / 8) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
            exp_g = 4'b0001;
`endif
            check($sformatf("hold_grant_c%0d", k), grant, exp_g);
        end

        // Async reset in the middle of source 3's grant.
        do_reset();
        req = 4'b1000;
        after_edge();
        check("rst3_grant_before", grant, 4'b1000);
        check("rst3_y_before", y, 4'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst3_grant_async", grant, 4'b0000);
        check("rst3_valid_async", {3'b000, valid}, 4'b0000);
        check("rst3_y_async", y, 4'b0000);
        @(negedge clk);
        req = 4'b1111;
        rst_n = 1'b1;
        after_edge();
        check("rst3_first_grant", grant, 4'b0001);
        check("rst3_first_y", y, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
